// File: rtl/sap1_control_unit.sv
// SAP-1 controller-sequencer: decodes the ring-counter T-state and the latched
// opcode into the 12-bit control word, and tracks halt, ring-counter integrity,
// illegal opcodes and retired instructions.
module sap1_control_unit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [5:0]       t,
  input  logic [3:0]       opcode,
  output logic [11:0]      con,
  output logic             hlt,
  output logic             t_err,
  output logic             ill_op,
  output logic [CNT_W-1:0] insn_cnt
);

  localparam logic [5:0] T1 = 6'b100000;
  localparam logic [5:0] T2 = 6'b010000;
  localparam logic [5:0] T3 = 6'b001000;
  localparam logic [5:0] T4 = 6'b000100;
  localparam logic [5:0] T5 = 6'b000010;
  localparam logic [5:0] T6 = 6'b000001;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
  localparam logic [11:0] CON_IDLE   = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_MEM_A  = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
  localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4 = 12'h3F2;

  logic [3:0] opcode_q;
  logic [5:0] exp_t;
  logic       one_hot;
  logic       mismatch;
  logic       op_defined;

  assign one_hot    = $onehot(t);
  // exp_t is always one-hot, so equality alone already implies a one-hot t
  assign mismatch   = (t != exp_t) || !one_hot;
  assign op_defined = (opcode_q == OP_LDA) || (opcode_q == OP_ADD) ||
                      (opcode_q == OP_SUB) || (opcode_q == OP_OUT) ||
                      (opcode_q == OP_HLT);

  // Capture the IR opcode on the falling edge that closes T3
  always_ff @(negedge clk or negedge res) begin
    if (!res)                 opcode_q <= '0;
    else if (t == T3 && !hlt) opcode_q <= opcode;
  end

  // Shadow ring counter: follow the expected T-state, flag and resync on mismatch
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      exp_t <= T1;
      t_err <= 1'b0;
    end else if (!hlt) begin
      if (!mismatch) begin
        exp_t <= {exp_t[0], exp_t[5:1]};
      end else begin
        t_err <= 1'b1;
        exp_t <= one_hot ? {t[0], t[5:1]} : T1;
      end
    end
  end

  // Halt latches in T4 of HLT and only reset clears it
  always_ff @(posedge clk or negedge res) begin
    if (!res)                              hlt <= 1'b0;
    else if (t == T4 && opcode_q == OP_HLT) hlt <= 1'b1;
  end

  // Sticky flag for executing an undefined opcode
  always_ff @(posedge clk or negedge res) begin
    if (!res)                          ill_op <= 1'b0;
    else if (t == T4 && !op_defined)   ill_op <= 1'b1;
  end

  // Count instructions that reach a clean T6 while running
  always_ff @(posedge clk or negedge res) begin
    if (!res)                               insn_cnt <= '0;
    else if (t == T6 && !hlt && !mismatch)  insn_cnt <= insn_cnt + CNT_W'(1);
  end

  // Control word decode from live T-state and latched opcode
  always_comb begin
    con = CON_IDLE;
    if (!hlt && one_hot) begin
      case (t)
        T1: con = CON_T1;
        T2: con = CON_T2;
        T3: con = CON_T3;
        T4: begin
          case (opcode_q)
            OP_LDA, OP_ADD, OP_SUB: con = CON_MEM_A;
            OP_OUT:                 con = CON_OUT_T4;
            default:                con = CON_IDLE;
          endcase
        end
        T5: begin
          case (opcode_q)
            OP_LDA:         con = CON_LDA_T5;
            OP_ADD, OP_SUB: con = CON_ALU_T5;
            default:        con = CON_IDLE;
          endcase
        end
        T6: begin
          case (opcode_q)
            OP_ADD:  con = CON_ADD_T6;
            OP_SUB:  con = CON_SUB_T6;
            default: con = CON_IDLE;
          endcase
        end
        default: con = CON_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_control_unit.sv
// Self-checking bench for sap1_control_unit: directed scenarios plus a
// randomized instruction stream, all checked against a table-driven model.
module tb_sap1_control_unit;

  logic        clk = 1'b0;
  logic        res;
  logic [5:0]  t;
  logic [3:0]  opcode;
  logic [11:0] con, con_b;
  logic        hlt, t_err, ill_op;
  logic        hlt_b, t_err_b, ill_op_b;
  logic [7:0]  insn_cnt;
  logic [1:0]  insn_cnt_b;

  int checks = 0;
  int errors = 0;

  // model state (T-states as numbers 1..6, 0 = not one-hot)
  logic [3:0]  m_op;
  int          m_exp;
  bit          m_hlt, m_terr, m_ill;
  logic [31:0] m_cnt;
  logic [5:0]  cur_t;
  logic [3:0]  cur_op;
  logic [11:0] obs_con, exp_con;

  sap1_control_unit #(.CNT_W(8)) dut (
    .clk(clk), .res(res), .t(t), .opcode(opcode), .con(con), .hlt(hlt),
    .t_err(t_err), .ill_op(ill_op), .insn_cnt(insn_cnt)
  );

  sap1_control_unit #(.CNT_W(2)) dut_b (
    .clk(clk), .res(res), .t(t), .opcode(opcode), .con(con_b), .hlt(hlt_b),
    .t_err(t_err_b), .ill_op(ill_op_b), .insn_cnt(insn_cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic int tnum(input logic [5:0] v);
    if ($countones(v) != 1) return 0;
    for (int i = 0; i < 6; i++) if (v[5-i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [5:0] tv_of(input int n);
    logic [5:0] one;
    one = 6'b100000;
    return one >> (n - 1);
  endfunction

  function automatic logic [11:0] ref_con(input logic [5:0] v, input logic [3:0] op, input bit h);
    int n;
    n = tnum(v);
    if (h || n == 0) return 12'h3E3;
    if (n == 1) return 12'h5E3;
    if (n == 2) return 12'hBE3;
    if (n == 3) return 12'h263;
    case (op)
      4'h0:    return (n == 4) ? 12'h1A3 : (n == 5) ? 12'h2C3 : 12'h3E3;
      4'h1:    return (n == 4) ? 12'h1A3 : (n == 5) ? 12'h2E1 : 12'h3C7;
      4'h2:    return (n == 4) ? 12'h1A3 : (n == 5) ? 12'h2E1 : 12'h3CF;
      4'hE:    return (n == 4) ? 12'h3F2 : 12'h3E3;
      default: return 12'h3E3;
    endcase
  endfunction

  // One T-state: drive just after the falling edge, sample con mid-cycle,
  // advance the model over the rising edge, return just after it.
  task automatic step(input logic [5:0] tv, input logic [3:0] op);
    int n;
    bit mm;
    @(negedge clk);
    if (tnum(cur_t) == 3 && !m_hlt) m_op = cur_op;
    #1 t = tv; opcode = op; cur_t = tv; cur_op = op;
    #2 obs_con = con; exp_con = ref_con(tv, m_op, m_hlt);
    @(posedge clk);
    n = tnum(tv);
    mm = (n == 0) || (n != m_exp);
    if (!m_hlt) begin
      if (mm) begin
        m_terr = 1;
        m_exp = (n == 0) ? 1 : (n % 6) + 1;
      end else begin
        m_exp = (m_exp % 6) + 1;
        if (n == 6) m_cnt = m_cnt + 1;
      end
    end
    if (n == 4 && m_op == 4'hF) m_hlt = 1;
    if (n == 4 && !(m_op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF})) m_ill = 1;
    #1;
  endtask

  task automatic assert_reset();
    #2 res = 1'b0;
    m_op = 4'h0; m_exp = 1; m_hlt = 0; m_terr = 0; m_ill = 0; m_cnt = 0;
  endtask

  task automatic release_reset();
    t = 6'b100000;
    @(posedge clk);
    #1 res = 1'b1;
    cur_t = t; cur_op = opcode;
  endtask

  task automatic test_reset();
    t = 6'b100000; opcode = 4'h0; cur_t = t; cur_op = opcode;
    assert_reset();
    #1;
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt got %b want 0", hlt); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL reset_t_err got %b want 0", t_err); end
    checks++; if (ill_op !== 1'b0) begin errors++; $display("FAIL reset_ill_op got %b want 0", ill_op); end
    checks++; if (insn_cnt !== 8'd0) begin errors++; $display("FAIL reset_insn_cnt got %0d want 0", insn_cnt); end
    checks++; if (con !== 12'h5E3) begin errors++; $display("FAIL reset_con got %h want 5e3", con); end
    release_reset();
  endtask

  task automatic test_add();
    logic [11:0] tbl [6];
    tbl[0] = 12'h5E3; tbl[1] = 12'hBE3; tbl[2] = 12'h263;
    tbl[3] = 12'h1A3; tbl[4] = 12'h2E1; tbl[5] = 12'h3C7;
    for (int n = 1; n <= 6; n++) begin
      step(tv_of(n), 4'h1);
      checks++;
      if (obs_con !== tbl[n-1]) begin errors++; $display("FAIL add_con T%0d got %h want %h", n, obs_con, tbl[n-1]); end
    end
    checks++; if (insn_cnt !== 8'd1) begin errors++; $display("FAIL add_insn_cnt got %0d want 1", insn_cnt); end
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL add_t_err got %b want 0", t_err); end
    checks++; if (ill_op !== 1'b0) begin errors++; $display("FAIL add_ill_op got %b want 0", ill_op); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3];
    ops[0] = 4'h0; ops[1] = 4'h2; ops[2] = 4'hE;
    for (int k = 0; k < 3; k++) begin
      for (int n = 1; n <= 6; n++) begin
        step(tv_of(n), ops[k]);
        checks++;
        if (obs_con !== exp_con) begin errors++; $display("FAIL b2b_con op%h T%0d got %h want %h", ops[k], n, obs_con, exp_con); end
        if (k == 0 && n == 5) begin
          checks++; if (obs_con !== 12'h2C3) begin errors++; $display("FAIL b2b_lda_t5 got %h want 2c3", obs_con); end
        end
        if (k == 1 && n == 6) begin
          checks++; if (obs_con !== 12'h3CF) begin errors++; $display("FAIL b2b_sub_t6 got %h want 3cf", obs_con); end
        end
        if (k == 2 && n == 4) begin
          checks++; if (obs_con !== 12'h3F2) begin errors++; $display("FAIL b2b_out_t4 got %h want 3f2", obs_con); end
        end
      end
    end
    checks++; if (insn_cnt !== 8'd4) begin errors++; $display("FAIL b2b_insn_cnt got %0d want 4", insn_cnt); end
  endtask

  task automatic test_halt();
    for (int n = 1; n <= 3; n++) step(tv_of(n), 4'hF);
    step(tv_of(4), 4'h1);
    checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL halt_set got %b want 1", hlt); end
    for (int n = 5; n <= 12; n++) begin
      step(tv_of(((n - 1) % 6) + 1), 4'h1);
      checks++;
      if (obs_con !== 12'h3E3) begin errors++; $display("FAIL halt_con step%0d got %h want 3e3", n, obs_con); end
    end
    checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b want 1", hlt); end
    checks++; if (insn_cnt !== m_cnt[7:0]) begin errors++; $display("FAIL halt_insn_cnt got %0d want %0d", insn_cnt, m_cnt[7:0]); end
    assert_reset();
    #1;
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL halt_clear got %b want 0", hlt); end
    release_reset();
  endtask

  task automatic test_skip();
    step(tv_of(1), 4'h1);
    step(tv_of(2), 4'h1);
    checks++; if (t_err !== 1'b0) begin errors++; $display("FAIL skip_pre_err got %b want 0", t_err); end
    step(tv_of(4), 4'h1);
    checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL skip_t_err got %b want 1", t_err); end
    for (int n = 5; n <= 6; n++) begin
      step(tv_of(n), 4'h1);
      checks++;
      if (obs_con !== exp_con) begin errors++; $display("FAIL skip_con T%0d got %h want %h", n, obs_con, exp_con); end
    end
    checks++; if (insn_cnt !== m_cnt[7:0]) begin errors++; $display("FAIL skip_insn_cnt got %0d want %0d", insn_cnt, m_cnt[7:0]); end
  endtask

  task automatic test_bad_t();
    logic [5:0] bad [2];
    bad[0] = 6'b000000; bad[1] = 6'b110000;
    for (int k = 0; k < 2; k++) begin
      assert_reset();
      release_reset();
      step(tv_of(1), 4'h1);
      step(bad[k], 4'h1);
      checks++; if (obs_con !== 12'h3E3) begin errors++; $display("FAIL badt_con %b got %h want 3e3", bad[k], obs_con); end
      checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL badt_t_err %b got %b want 1", bad[k], t_err); end
      for (int n = 1; n <= 6; n++) step(tv_of(n), 4'h1);
      checks++; if (insn_cnt !== 8'd1) begin errors++; $display("FAIL badt_resync_cnt %b got %0d want 1", bad[k], insn_cnt); end
    end
  endtask

  task automatic test_illegal();
    assert_reset();
    release_reset();
    for (int n = 1; n <= 6; n++) begin
      step(tv_of(n), 4'h7);
      if (n == 3) begin
        checks++; if (ill_op !== 1'b0) begin errors++; $display("FAIL ill_early got %b want 0", ill_op); end
      end
      if (n >= 4) begin
        checks++; if (obs_con !== 12'h3E3) begin errors++; $display("FAIL ill_con T%0d got %h want 3e3", n, obs_con); end
      end
    end
    checks++; if (ill_op !== 1'b1) begin errors++; $display("FAIL ill_op got %b want 1", ill_op); end
    checks++; if (insn_cnt !== 8'd1) begin errors++; $display("FAIL ill_cnt got %0d want 1", insn_cnt); end
    for (int k = 0; k < 3; k++) for (int n = 1; n <= 6; n++) step(tv_of(n), 4'h7);
    checks++; if (insn_cnt !== 8'd4) begin errors++; $display("FAIL wrap_cnt8 got %0d want 4", insn_cnt); end
    checks++; if (insn_cnt_b !== 2'd0) begin errors++; $display("FAIL wrap_cnt2 got %0d want 0", insn_cnt_b); end
    for (int n = 1; n <= 5; n++) step(tv_of(n), 4'h1);
    assert_reset();
    #1;
    checks++; if (con !== 12'h2C3) begin errors++; $display("FAIL midrst_con got %h want 2c3", con); end
    checks++; if (ill_op !== 1'b0) begin errors++; $display("FAIL midrst_ill got %b want 0", ill_op); end
    checks++; if (insn_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", insn_cnt); end
    checks++; if (t_err !== 1'b0 || hlt !== 1'b0) begin errors++; $display("FAIL midrst_flags got %b%b want 00", t_err, hlt); end
    release_reset();
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [5:0] tv;
    assert_reset();
    release_reset();
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
      for (int n = 1; n <= 6; n++) begin
        tv = tv_of(n);
        if ($urandom_range(0, 19) == 0) tv = 6'($urandom_range(0, 63));
        step(tv, op);
        checks++; if (obs_con !== exp_con) begin errors++; $display("FAIL rnd_con i%0d t=%b got %h want %h", k, tv, obs_con, exp_con); end
        checks++; if (hlt !== m_hlt) begin errors++; $display("FAIL rnd_hlt i%0d got %b want %b", k, hlt, m_hlt); end
        checks++; if (t_err !== m_terr) begin errors++; $display("FAIL rnd_t_err i%0d got %b want %b", k, t_err, m_terr); end
        checks++; if (ill_op !== m_ill) begin errors++; $display("FAIL rnd_ill_op i%0d got %b want %b", k, ill_op, m_ill); end
        checks++; if (insn_cnt !== m_cnt[7:0]) begin errors++; $display("FAIL rnd_cnt i%0d got %0d want %0d", k, insn_cnt, m_cnt[7:0]); end
        checks++; if (insn_cnt_b !== m_cnt[1:0]) begin errors++; $display("FAIL rnd_cnt2 i%0d got %0d want %0d", k, insn_cnt_b, m_cnt[1:0]); end
      end
    end
  endtask

  initial begin
    res = 1'b1;
    t = 6'b100000;
    opcode = 4'h0;
    test_reset();
    test_add();
    test_back_to_back();
    test_halt();
    test_skip();
    test_bad_t();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
